// File: rtl/sht31_pkg.sv
`timescale 1ns/1ps
// sht31_pkg: FSM state type, SHT31 command codes, CRC-8 constants and the
// CRC helper shared by the SHT31 I2C responder.
package sht31_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_e;

  localparam logic [15:0] CMD_MEAS_HR    = 16'h2400;
  localparam logic [15:0] CMD_MEAS_HR_CS = 16'h2C06;
  localparam logic [15:0] CMD_SOFT_RST   = 16'h30A2;

  localparam logic [7:0]  CRC_POLY = 8'h31;
  localparam logic [7:0]  CRC_INIT = 8'hFF;

  // Number of meaningful bytes in a measurement readout; later bytes read 0xFF.
  localparam logic [2:0]  RD_LEN = 3'd6;

  // SHT31 CRC-8 over a 16-bit word, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8(input logic [15:0] data);
    logic [7:0] crc;
    crc = CRC_INIT;
    for (int i = 15; i >= 0; i--) begin
      if (crc[7] ^ data[i]) begin
        crc = {crc[6:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc = {crc[6:0], 1'b0};
      end
    end
    return crc;
  endfunction

endpackage

// File: rtl/sht31_i2c_responder_i2c_line_sync.sv
`timescale 1ns/1ps
// i2c_line_sync: double-flop synchronizers for SCL/SDA plus edge, START and
// STOP detection on the synchronized lines. Bus conditions are ignored while
// the target itself holds SDA low, so its own ACK/data bits never look like
// START or STOP.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda_i,
  input  logic drive_low,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  // Synchronizer chains plus one history stage for edge detection; idle bus is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  // Edge and bus-condition decode from the synchronized and delayed samples.
  always_comb begin
    scl_rise  = scl_sync_q & ~scl_prev_q;
    scl_fall  = ~scl_sync_q & scl_prev_q;
    start_det = ~drive_low & scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    stop_det  = ~drive_low & scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
    sda_s     = sda_sync_q;
  end

endmodule

// File: rtl/sht31_i2c_responder.sv
`timescale 1ns/1ps
// sht31_i2c_responder: oversampled I2C target emulating an SHT31 sensor.
// Accepts 2-byte commands, arms a measurement on 0x2400/0x2C06, clears it on
// soft reset 0x30A2, and returns TEMP/HUM raw words with CRC bytes.
// Define SHT31_CRC_EN to build real CRC bytes; otherwise they read as 0xFF.
module sht31_i2c_responder #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h44,
  parameter logic [15:0] TEMP_RAW   = 16'h6666,
  parameter logic [15:0] HUM_RAW    = 16'h8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  input  logic        sda_i,
  output logic        sda_o,
  output logic [15:0] last_cmd,
  output logic        data_ready
);
  import sht31_pkg::*;

`ifdef SHT31_CRC_EN
  localparam logic [7:0] CRC_TEMP = crc8(TEMP_RAW);
  localparam logic [7:0] CRC_HUM  = crc8(HUM_RAW);
`else
  localparam logic [7:0] CRC_TEMP = 8'hFF;
  localparam logic [7:0] CRC_HUM  = 8'hFF;
`endif

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [6:0]  tx_q, tx_d;
  logic        sda_o_q, sda_o_d;
  logic [15:0] last_cmd_q, last_cmd_d;
  logic        data_ready_q, data_ready_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_idx_q, wr_idx_d;
  logic        rd_mode_q, rd_mode_d;
  logic        rd_txn_q, rd_txn_d;

  logic [7:0]  rx_byte;
  logic [7:0]  cur_byte;
  logic [15:0] new_cmd;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda_i     (sda_i),
    .drive_low (~sda_o_q),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  // Readout byte selected by the read pointer; positions past the sixth read 0xFF.
  always_comb begin
    case (rd_ptr_q)
      3'd0:    cur_byte = TEMP_RAW[15:8];
      3'd1:    cur_byte = TEMP_RAW[7:0];
      3'd2:    cur_byte = CRC_TEMP;
      3'd3:    cur_byte = HUM_RAW[15:8];
      3'd4:    cur_byte = HUM_RAW[7:0];
      3'd5:    cur_byte = CRC_HUM;
      default: cur_byte = 8'hFF;
    endcase
  end

  // FSM next-state and datapath: bit sampling on SCL rise, SDA drive on SCL fall.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    sda_o_d      = sda_o_q;
    last_cmd_d   = last_cmd_q;
    data_ready_d = data_ready_q;
    rd_ptr_d     = rd_ptr_q;
    wr_idx_d     = wr_idx_q;
    rd_mode_d    = rd_mode_q;
    rd_txn_d     = rd_txn_q;
    rx_byte      = {shift_q, sda_s};
    new_cmd      = {last_cmd_q[15:8], rx_byte};

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_o_d   = 1'b1;
      rd_txn_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_o_d   = 1'b1;
      rd_txn_d  = 1'b0;
      if (rd_txn_q) begin
        data_ready_d = 1'b0;
      end
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (rx_byte[7:1] != SLAVE_ADDR) begin
                state_d = IGNORE;
              end else if (!rx_byte[0]) begin
                state_d   = ADDR_ACK;
                rd_mode_d = 1'b0;
                wr_idx_d  = 2'd0;
              end else if (data_ready_q) begin
                state_d   = ADDR_ACK;
                rd_mode_d = 1'b1;
                rd_txn_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR_ACK: begin
          // First fall pulls SDA low for the ACK; the second ends it.
          if (scl_fall) begin
            if (sda_o_q) begin
              sda_o_d = 1'b0;
            end else if (rd_mode_q) begin
              sda_o_d   = cur_byte[7];
              tx_d      = cur_byte[6:0];
              rd_ptr_d  = (rd_ptr_q < RD_LEN) ? rd_ptr_q + 3'd1 : rd_ptr_q;
              bit_cnt_d = 4'd0;
              state_d   = RD_BYTE;
            end else begin
              sda_o_d   = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = WR_BYTE;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              state_d   = WR_ACK;
              if (wr_idx_q == 2'd0) begin
                last_cmd_d[15:8] = rx_byte;
                wr_idx_d         = 2'd1;
              end else if (wr_idx_q == 2'd1) begin
                last_cmd_d[7:0] = rx_byte;
                wr_idx_d        = 2'd2;
                if (new_cmd == CMD_MEAS_HR || new_cmd == CMD_MEAS_HR_CS) begin
                  data_ready_d = 1'b1;
                  rd_ptr_d     = 3'd0;
                end else if (new_cmd == CMD_SOFT_RST) begin
                  data_ready_d = 1'b0;
                end
              end
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (sda_o_q) begin
              sda_o_d = 1'b0;
            end else begin
              sda_o_d = 1'b1;
              state_d = WR_BYTE;
            end
          end
        end
        RD_BYTE: begin
          // Count bits on rise; shift the next bit out (or release) on fall.
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_o_d = 1'b1;
              state_d = RD_ACK;
            end else begin
              sda_o_d = tx_q[6];
              tx_d    = {tx_q[5:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          // bit_cnt 9 marks "master ACKed, load next byte on the coming fall".
          if (scl_rise) begin
            if (sda_s) begin
              state_d = IGNORE;
            end else begin
              bit_cnt_d = 4'd9;
            end
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            sda_o_d   = cur_byte[7];
            tx_d      = cur_byte[6:0];
            rd_ptr_d  = (rd_ptr_q < RD_LEN) ? rd_ptr_q + 3'd1 : rd_ptr_q;
            bit_cnt_d = 4'd0;
            state_d   = RD_BYTE;
          end
        end
        IDLE, IGNORE: begin
        end
        default: begin
          state_d = IDLE;
          sda_o_d = 1'b1;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 7'd0;
      tx_q         <= 7'd0;
      sda_o_q      <= 1'b1;
      last_cmd_q   <= 16'h0000;
      data_ready_q <= 1'b0;
      rd_ptr_q     <= 3'd0;
      wr_idx_q     <= 2'd0;
      rd_mode_q    <= 1'b0;
      rd_txn_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      sda_o_q      <= sda_o_d;
      last_cmd_q   <= last_cmd_d;
      data_ready_q <= data_ready_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_idx_q     <= wr_idx_d;
      rd_mode_q    <= rd_mode_d;
      rd_txn_q     <= rd_txn_d;
    end
  end

  assign sda_o      = sda_o_q;
  assign last_cmd   = last_cmd_q;
  assign data_ready = data_ready_q;

endmodule

// File: tb/tb_sht31_i2c_responder.sv
`timescale 1ns/1ps
// Testbench for sht31_i2c_responder: bit-banged I2C master against a
// transaction-level sensor model (command register, ready flag, read pointer).
module tb_sht31_i2c_responder;

  localparam logic [15:0] T_RAW = 16'hBEEF;
  localparam logic [15:0] H_RAW = 16'h5A3C;
  localparam time Q = 50ns;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  wire         sda_bus;
  logic        sda_o;
  logic [15:0] last_cmd;
  logic        data_ready;

  assign sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  sht31_i2c_responder #(
    .SLAVE_ADDR (7'h44),
    .TEMP_RAW   (T_RAW),
    .HUM_RAW    (H_RAW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl        (scl),
    .sda_i      (sda_bus),
    .sda_o      (sda_o),
    .last_cmd   (last_cmd),
    .data_ready (data_ready)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [15:0] m_cmd = 16'h0000;
  logic        m_ready = 1'b0;
  int          m_ptr = 0;

  function automatic logic [7:0] crc_model(input logic [15:0] w);
    logic [7:0] c;
    logic [7:0] bytes [2];
    c = 8'hFF;
    bytes[0] = w[15:8];
    bytes[1] = w[7:0];
    for (int b = 0; b < 2; b++) begin
      c = c ^ bytes[b];
      for (int k = 0; k < 8; k++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h31) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [7:0] exp_byte(input int p);
    logic [7:0] tc, hc;
`ifdef SHT31_CRC_EN
    tc = crc_model(T_RAW);
    hc = crc_model(H_RAW);
`else
    tc = 8'hFF;
    hc = 8'hFF;
`endif
    case (p)
      0: return T_RAW[15:8];
      1: return T_RAW[7:0];
      2: return tc;
      3: return H_RAW[15:8];
      4: return H_RAW[7:0];
      5: return hc;
      default: return 8'hFF;
    endcase
  endfunction

  // Model reaction to one accepted write byte at position idx.
  task automatic model_write(input int idx, input logic [7:0] b);
    if (idx == 0) m_cmd[15:8] = b;
    else if (idx == 1) begin
      m_cmd[7:0] = b;
      if (m_cmd == 16'h2400 || m_cmd == 16'h2C06) begin
        m_ready = 1'b1;
        m_ptr = 0;
      end else if (m_cmd == 16'h30A2) m_ready = 1'b0;
    end
  endtask

  // ---------------- bus primitives ----------------
  task automatic bus_start();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
  endtask

  task automatic put_byte(input logic [7:0] v, output logic acked);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(a);
    acked = ~a;
  endtask

  task automatic get_byte(input logic master_ack, output logic [7:0] v);
    logic b;
    v = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(~master_ack);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  // Full write transaction: address 0x44 write + 2 command bytes.
  task automatic write_cmd(input logic [15:0] cmd, output logic [2:0] acks);
    bus_start();
    put_byte(8'h88, acks[2]);
    put_byte(cmd[15:8], acks[1]);
    put_byte(cmd[7:0], acks[0]);
    bus_stop();
    settle();
    $display("txn write cmd=%04h acks=%b", cmd, acks);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (sda_o !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda_o); end
    checks++; if (last_cmd !== 16'h0000) begin failures++; $display("FAIL reset_last_cmd got=%04h exp=0000", last_cmd); end
    checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", data_ready); end
  endtask

  task automatic test_measure_read();
    logic a;
    logic [7:0] v;
    logic [7:0] cmdb [3];
    cmdb[0] = 8'h88; cmdb[1] = 8'h24; cmdb[2] = 8'h00;
    bus_start();
    for (int i = 0; i < 3; i++) begin
      put_byte(cmdb[i], a);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL meas_ack%0d got=%b exp=1", i, a); end
      if (i > 0) model_write(i - 1, cmdb[i]);
    end
    @(negedge clk);
    checks++; if (last_cmd !== m_cmd) begin failures++; $display("FAIL meas_last_cmd got=%04h exp=%04h", last_cmd, m_cmd); end
    checks++; if (data_ready !== m_ready) begin failures++; $display("FAIL meas_ready got=%b exp=%b", data_ready, m_ready); end
    bus_start();
    put_byte(8'h89, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL rd_hdr_ack got=%b exp=1", a); end
    for (int i = 0; i < 6; i++) begin
      get_byte(i < 5, v);
      checks++; if (v !== exp_byte(m_ptr)) begin failures++; $display("FAIL rd_byte%0d got=%02h exp=%02h", i, v, exp_byte(m_ptr)); end
      m_ptr++;
    end
    bus_stop();
    m_ready = 1'b0;
    settle();
    $display("txn measure+read6 done");
    checks++; if (data_ready !== m_ready) begin failures++; $display("FAIL rd_stop_ready got=%b exp=%b", data_ready, m_ready); end
  endtask

  task automatic test_wrong_addr();
    logic a;
    bus_start();
    put_byte(8'h8A, a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL wrong_addr_nack got=%b exp=0", a); end
    put_byte(8'h30, a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL wrong_addr_data got=%b exp=0", a); end
    bus_stop();
    settle();
    $display("txn wrong address 0x45");
    checks++; if (last_cmd !== m_cmd) begin failures++; $display("FAIL wrong_addr_cmd got=%04h exp=%04h", last_cmd, m_cmd); end
  endtask

  task automatic test_read_not_ready();
    logic a;
    bus_start();
    put_byte(8'h89, a);
    bus_stop();
    settle();
    $display("txn read header while not ready");
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL notready_nack got=%b exp=0", a); end
    checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL notready_ready got=%b exp=0", data_ready); end
  endtask

  task automatic test_soft_reset();
    logic [2:0] acks;
    logic a;
    write_cmd(16'h2C06, acks);
    model_write(0, 8'h2C); model_write(1, 8'h06);
    checks++; if (data_ready !== m_ready) begin failures++; $display("FAIL sr_meas_ready got=%b exp=%b", data_ready, m_ready); end
    write_cmd(16'h30A2, acks);
    model_write(0, 8'h30); model_write(1, 8'hA2);
    checks++; if (acks !== 3'b111) begin failures++; $display("FAIL sr_acks got=%b exp=111", acks); end
    checks++; if (data_ready !== m_ready) begin failures++; $display("FAIL sr_ready got=%b exp=%b", data_ready, m_ready); end
    checks++; if (last_cmd !== m_cmd) begin failures++; $display("FAIL sr_last_cmd got=%04h exp=%04h", last_cmd, m_cmd); end
    bus_start();
    put_byte(8'h89, a);
    bus_stop();
    settle();
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL sr_rd_nack got=%b exp=0", a); end
  endtask

  task automatic test_read_overrun();
    logic [2:0] acks;
    logic a;
    logic [7:0] v;
    write_cmd(16'h2400, acks);
    model_write(0, 8'h24); model_write(1, 8'h00);
    bus_start();
    put_byte(8'h89, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL ovr_hdr got=%b exp=1", a); end
    for (int i = 0; i < 8; i++) begin
      get_byte(i < 7, v);
      if (i >= 5) begin
        checks++; if (v !== exp_byte(m_ptr)) begin failures++; $display("FAIL ovr_byte%0d got=%02h exp=%02h", i, v, exp_byte(m_ptr)); end
      end
      m_ptr++;
    end
    bus_stop();
    m_ready = 1'b0;
    settle();
    $display("txn read8 overrun");
  endtask

  task automatic test_reset_mid_read();
    logic [2:0] acks;
    logic a, b;
    logic [7:0] e;
    write_cmd(16'h2400, acks);
    model_write(0, 8'h24); model_write(1, 8'h00);
    e = exp_byte(0);
    bus_start();
    put_byte(8'h89, a);
    get_bit(b);
    checks++; if (b !== e[7]) begin failures++; $display("FAIL mid_bit7 got=%b exp=%b", b, e[7]); end
    sda_m = 1'b1; #Q; scl = 1'b1; #Q;
    checks++; if (sda_o !== e[6]) begin failures++; $display("FAIL mid_bit6 got=%b exp=%b", sda_o, e[6]); end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    m_cmd = 16'h0000; m_ready = 1'b0; m_ptr = 0;
    checks++; if (sda_o !== 1'b1) begin failures++; $display("FAIL mid_rst_sda got=%b exp=1", sda_o); end
    checks++; if (data_ready !== m_ready) begin failures++; $display("FAIL mid_rst_ready got=%b exp=%b", data_ready, m_ready); end
    checks++; if (last_cmd !== m_cmd) begin failures++; $display("FAIL mid_rst_cmd got=%04h exp=%04h", last_cmd, m_cmd); end
    @(negedge clk);
    rst_n = 1'b1;
    #Q; scl = 1'b0; #Q;
    bus_stop();
    settle();
    $display("txn reset during read");
  endtask

  task automatic test_random();
    logic a;
    logic [7:0] v, b;
    logic [15:0] cmd;
    logic [6:0] addr;
    int n, sel;
    for (int it = 0; it < 10; it++) begin
      sel = $urandom_range(0, 3);
      cmd = (sel == 0) ? 16'h2400 : (sel == 1) ? 16'h2C06 : (sel == 2) ? 16'h30A2 : 16'($urandom);
      n = $urandom_range(1, 4);
      addr = 7'h44;
      if ($urandom_range(0, 5) == 0) addr = 7'h44 ^ 7'($urandom_range(1, 127));
      bus_start();
      put_byte({addr, 1'b0}, a);
      checks++; if (a !== (addr == 7'h44)) begin failures++; $display("FAIL rnd%0d_addr_ack got=%b exp=%b", it, a, addr == 7'h44); end
      if (addr == 7'h44) begin
        for (int i = 0; i < n; i++) begin
          b = (i == 0) ? cmd[15:8] : (i == 1) ? cmd[7:0] : 8'($urandom);
          put_byte(b, a);
          checks++; if (a !== 1'b1) begin failures++; $display("FAIL rnd%0d_wr_ack%0d got=%b exp=1", it, i, a); end
          model_write(i, b);
        end
      end
      bus_stop();
      settle();
      $display("txn rnd%0d write addr=%02h cmd=%04h n=%0d", it, addr, cmd, n);
      checks++; if (last_cmd !== m_cmd) begin failures++; $display("FAIL rnd%0d_cmd got=%04h exp=%04h", it, last_cmd, m_cmd); end
      checks++; if (data_ready !== m_ready) begin failures++; $display("FAIL rnd%0d_ready got=%b exp=%b", it, data_ready, m_ready); end
      if ($urandom_range(0, 1) == 1) begin
        bus_start();
        put_byte(8'h89, a);
        checks++; if (a !== m_ready) begin failures++; $display("FAIL rnd%0d_rd_hdr got=%b exp=%b", it, a, m_ready); end
        if (a === 1'b1) begin
          n = $urandom_range(1, 7);
          for (int i = 0; i < n; i++) begin
            get_byte(i < n - 1, v);
            checks++; if (v !== exp_byte(m_ptr)) begin failures++; $display("FAIL rnd%0d_rd%0d got=%02h exp=%02h", it, i, v, exp_byte(m_ptr)); end
            m_ptr++;
          end
          m_ready = 1'b0;
        end
        bus_stop();
        settle();
        $display("txn rnd%0d read", it);
        checks++; if (data_ready !== m_ready) begin failures++; $display("FAIL rnd%0d_rd_ready got=%b exp=%b", it, data_ready, m_ready); end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_measure_read();
    test_wrong_addr();
    test_read_not_ready();
    test_soft_reset();
    test_read_overrun();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sht31_i2c_responder.md
# sht31_i2c_responder

Synthesizable, clock-oversampled I2C target that emulates an SHT31 humidity/temperature sensor at a configurable 7-bit address. It sits on the board-level I2C bus next to the SoC's I2C master in integration benches and FPGA bring-up, and returns fixed raw measurement words with SHT31-format CRC bytes. The bus is modelled as pseudo open-drain: the block sees the wired-AND bus value on `sda_i` and only ever releases (1) or pulls low (0) on `sda_o`.

## Interface
- `SLAVE_ADDR`, 7'h44, 7-bit target address.
- `TEMP_RAW`, 16'h6666, raw temperature word returned after a measurement.
- `HUM_RAW`, 16'h8000, raw humidity word returned after a measurement.

- `clk`  in  1  system clock; must be ≥ 8× SCL frequency.
- `rst_n`  in  1  synchronous, active-low reset.
- `scl`  in  1  bus SCL (driven by master only, no clock stretching).
- `sda_i`  in  1  wired-AND SDA bus value.
- `sda_o`  out  1  1 = released, 0 = pull low.
- `last_cmd`  out  16  most recent 2-byte command written (MSB first).
- `data_ready`  out  1  measurement available for readout.

## Operation
- `scl`/`sda_i` pass through 2-FF synchronizers, then edge detection on the synchronized values.
- START: SDA falls while SCL high. Legal in any state, repeated START included; resets the bit counter and enters ADDR.
- STOP: SDA rises while SCL high; enters IDLE and releases SDA.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- Master-to-target bits are sampled on SCL rising edges, MSB first. After 8 bits the target evaluates the byte.
- ADDR:
  - address ≠ `SLAVE_ADDR` → IGNORE (SDA stays released, so the master sees a NACK).
  - match with R/W=0 → ACK, then WR_BYTE.
  - match with R/W=1 and `data_ready`=1 → ACK, then RD_BYTE.
  - match with R/W=1 and `data_ready`=0 → NACK, then IGNORE.
- ACK drive: `sda_o`=0 from the SCL falling edge after bit 8 until the next SCL falling edge.
- Write bytes are always ACKed. Byte 0 goes to `last_cmd[15:8]` and byte 1 to `last_cmd[7:0]`; further bytes are ACKed and discarded.
- At the second command byte:
  - if {b0,b1} ∈ {16'h2400, 16'h2C06} → `data_ready`=1 and the read pointer is set to 0.
  - 16'h30A2 (soft reset) → `data_ready`=0.
- Read sequence: TEMP_RAW[15:8], TEMP_RAW[7:0], CRC(TEMP), HUM_RAW[15:8], HUM_RAW[7:0], CRC(HUM). Bytes past the sixth return 8'hFF.
- Read drive: each data bit is placed on `sda_o` at an SCL falling edge (the first bit on the falling edge that ends the address ACK). SDA is released at the falling edge after bit 8.
- The master's ACK/NACK is sampled on the 9th rising edge. ACK → next byte. NACK → IGNORE until STOP/START.
- A STOP that ends a read transaction clears `data_ready`.
- CRC-8: polynomial 0x31, init 0xFF, no reflection, no final XOR, computed over the two data bytes.

## Timing
- Reset: `sda_o`=1, state IDLE, `last_cmd`=0, `data_ready`=0, bit counter 0, read pointer 0.
- A reset mid-transaction releases SDA on the next `clk` edge.
- Input-to-detect latency: 2 clk (synchronizer) + 1 clk (edge register).
- `sda_o` updates on the clk edge after the SCL-falling detection, so it changes 3–4 clk after the real SCL fall and always while SCL is low.
- START/STOP detection is suppressed while the target itself is driving SDA low.
- `last_cmd` and `data_ready` update 1 clk after the ACK-bit decision point.

## Configuration
- `SHT31_CRC_EN` defined: CRC bytes are computed as specified above.
- `SHT31_CRC_EN` undefined: the CRC byte positions return 8'hFF and no CRC logic is built.

## Structure
- Package `sht31_pkg` holds:
  - the state enum;
  - command constants CMD_MEAS_HR=16'h2400, CMD_MEAS_HR_CS=16'h2C06, CMD_SOFT_RST=16'h30A2;
  - CRC polynomial/init constants;
  - a `crc8` function.
- Sub-module `i2c_line_sync` contains the two synchronizers plus rise/fall/START/STOP detection; the FSM lives in the top module.

## Test plan
- Write 0x88, 0x24, 0x00 with TEMP_RAW=HUM_RAW=16'hBEEF → all three ACKed; `last_cmd`=16'h2400, `data_ready`=1. Then repeated START, 0x89, read 6 bytes with ACK,…,ACK,NACK, STOP → bytes BE EF 92 BE EF 92; `data_ready`=0.
- Address 0x8A (0x45 write) → NACK (SDA high on the 9th clock); no state change until STOP.
- Read header 0x89 before any measurement command → NACK; `data_ready` stays 0.
- Write 0x88, 0x30, 0xA2 after a measurement → ACKs; `data_ready`=0; a following read header is NACKed.
- Read 8 bytes after a measurement → bytes 7–8 = 0xFF. Assert `rst_n`=0 during bit 3 of a read → `sda_o`=1 on the next clk; `data_ready`=0.
- Build without `SHT31_CRC_EN` → read sequence BE EF FF BE EF FF.
